// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing sdram controller port 0 among NUM_REQ requesters.
// Optional watchdog on stalled accesses: define SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*BE_WIDTH-1:0]      req_byte_en,
  output logic [NUM_REQ-1:0]               req_accept,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [DATA_WIDTH-1:0]            rsp_q,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            p0_addr,
  output logic [DATA_WIDTH-1:0]            p0_data,
  output logic [BE_WIDTH-1:0]              p0_byte_en,
  output logic                             p0_wr_req,
  output logic                             p0_rd_req,
  input  logic                             p0_available,
  input  logic                             p0_ready,
  input  logic [DATA_WIDTH-1:0]            p0_q,
  output logic                             arb_err
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  r_state;
  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last_grant;
  logic                    r_we;
  logic [NUM_REQ-1:0]      r_req_accept;
  logic [NUM_REQ-1:0]      r_req_done;
  logic [DATA_WIDTH-1:0]   r_rsp_q;
  logic                    r_busy;
  logic [ADDR_WIDTH-1:0]   r_p0_addr;
  logic [DATA_WIDTH-1:0]   r_p0_data;
  logic [BE_WIDTH-1:0]     r_p0_byte_en;
  logic                    r_p0_wr_req;
  logic                    r_p0_rd_req;
  logic                    r_arb_err;

  logic [GW-1:0]           w_grant;
  logic [GW-1:0]           w_idx;
  logic                    w_found;

  // First pending requester after the last one served, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_we         <= 1'b0;
      r_req_accept <= '0;
      r_req_done   <= '0;
      r_rsp_q      <= '0;
      r_busy       <= 1'b0;
      r_p0_addr    <= '0;
      r_p0_data    <= '0;
      r_p0_byte_en <= '0;
      r_p0_wr_req  <= 1'b0;
      r_p0_rd_req  <= 1'b0;
      r_arb_err    <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_wd_cnt     <= '0;
`endif
    end else begin
      r_p0_wr_req  <= 1'b0;
      r_p0_rd_req  <= 1'b0;
      r_req_accept <= '0;
      r_req_done   <= '0;
      r_arb_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (p0_available && w_found) begin
            r_grant      <= w_grant;
            r_we         <= req_we[w_grant];
            r_p0_addr    <= req_addr[32'(w_grant) * ADDR_WIDTH +: ADDR_WIDTH];
            r_p0_data    <= req_data[32'(w_grant) * DATA_WIDTH +: DATA_WIDTH];
            r_p0_byte_en <= req_byte_en[32'(w_grant) * BE_WIDTH +: BE_WIDTH];
            r_p0_wr_req  <= req_we[w_grant];
            r_p0_rd_req  <= !req_we[w_grant];
            r_req_accept <= NUM_REQ'(1) << w_grant;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
            r_wd_cnt     <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (p0_ready) begin
            r_req_done   <= NUM_REQ'(1) << r_grant;
            if (!r_we) begin
              r_rsp_q <= p0_q;
            end
            r_last_grant <= r_grant;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          // Abandon a stalled access; read data is left untouched.
          else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_req_done   <= NUM_REQ'(1) << r_grant;
            r_arb_err    <= 1'b1;
            r_last_grant <= r_grant;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_accept = r_req_accept;
  assign req_done   = r_req_done;
  assign rsp_q      = r_rsp_q;
  assign busy       = r_busy;
  assign p0_addr    = r_p0_addr;
  assign p0_data    = r_p0_data;
  assign p0_byte_en = r_p0_byte_en;
  assign p0_wr_req  = r_p0_wr_req;
  assign p0_rd_req  = r_p0_rd_req;
  assign arb_err    = r_arb_err;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Round-robin arbiter that shares the single port 0 of the sdram controller among NUM_REQ requesters (video scanout, CPU, DMA).
- Captures one request at a time, drives the controller's p0_* request interface, waits for p0_ready, then returns read data and a done strobe to the granted requester.
- Sits between client logic and the sdram controller in the same clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 21, word address width (matches p0_addr)
- DATA_WIDTH, 32, data width (matches p0_data/p0_q)
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- TIMEOUT_CYCLES, 64, watchdog limit (optional feature only)

Ports:
- clk  in  1  system clock; sdram controller runs on the same clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request, level, held until req_accept
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data
- req_byte_en  in  NUM_REQ*BE_WIDTH  packed byte enables
- req_accept  out  NUM_REQ  one-cycle pulse: request captured
- req_done  out  NUM_REQ  one-cycle pulse: access complete, rsp_q valid for reads
- rsp_q  out  DATA_WIDTH  read data, held until next read completes
- busy  out  1  access outstanding
- p0_addr, p0_data, p0_byte_en  out  ADDR/DATA/BE  to controller, stable for the whole access
- p0_wr_req, p0_rd_req  out  1  one-cycle request strobes
- p0_available  in  1  controller can accept a command
- p0_ready  in  1  controller completion pulse
- p0_q  in  DATA_WIDTH  controller read data, valid with p0_ready
- arb_err  out  1  timeout pulse (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, WAIT.
- IDLE: if p0_available=1 and any req_valid=1, grant g = first set bit searching from last_grant+1 with wrap-around.
  - Same edge: register p0_addr/p0_data/p0_byte_en from slice g. Pulse p0_wr_req (req_we[g]=1) or p0_rd_req (req_we[g]=0) for exactly one cycle. Pulse req_accept[g]. Set busy=1. Go to WAIT.
  - Issue latency: strobe is visible the cycle after the first clk edge that sees req_valid & p0_available.
- IDLE with p0_available=0: no grant. Requests stay pending; requester must hold its fields stable.
- WAIT: p0_* fields held constant; strobes stay 0; further req_valid ignored.
  - On p0_ready=1: pulse req_done[g]; if a read, rsp_q<=p0_q; last_grant<=g; busy<=0; go to IDLE.
  - Next grant can issue in the cycle after the done pulse, so back-to-back accesses have a 1-cycle IDLE gap.
- Only one access is ever outstanding. Grants are exclusive: req_accept and req_done are one-hot or zero.
- A requester that drops req_valid before accept is simply not served. Dropping it after accept has no effect.
- Simultaneous p0_ready in IDLE is ignored (spurious).
- Fairness: a continuously requesting client waits at most NUM_REQ-1 accesses.
- Reset mid-access: abandons the access with no done pulse. The controller must be reset together with the arbiter.

Optional Feature:
- Macro SDRAM_ARB_TIMEOUT_EN.
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without p0_ready:
  - pulse arb_err and req_done[g]; rsp_q is unchanged;
  - last_grant<=g; return to IDLE.
- Not defined: no counter; WAIT waits indefinitely; arb_err constant 0.

Test Plan:
- Single write: requester 1 writes addr 21'h002020, data 32'h1234, byte_en 4'hf. Expect: one p0_wr_req pulse with those values; req_accept[1] on the same cycle; req_done[1] on the cycle after p0_ready; busy high in between.
- Read-back: requester 0 reads 21'h002020. Expect: p0_rd_req pulse; rsp_q=32'h1234 with req_done[0].
- Round-robin: all 3 requesters hold valid after reset. Expect grant order 0,1,2,0. Each gets req_done before the next p0_*_req. p0_addr is constant within each access.
- Backpressure: hold p0_available=0 for 20 cycles while req_valid[2]=1. Expect: no strobe and no accept. Strobe issues on the cycle after p0_available rises.
- Reset mid-access: pull reset_n low during WAIT. Expect all outputs 0 immediately and no req_done. After release, requester 0 is served first.
- Timeout (SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64): never assert p0_ready. Expect arb_err and req_done[g] after 64 WAIT cycles, then the next requester is granted.
